// File: rtl/chnl_tx_mux_pkg.sv
// Shared types and constants for the multi-source CHNL transmitter.
// Header beat layout: [31:24] source id, [23:8] payload length in uint32, [7:0] sequence number.
package chnl_tx_mux_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  localparam int unsigned SEQ_W       = 8;
  localparam int unsigned HDR_SEL_LSB = 24;
  localparam int unsigned HDR_SEL_W   = 8;
  localparam int unsigned HDR_LEN_LSB = 8;
  localparam int unsigned HDR_LEN_W   = 16;
  localparam int unsigned HDR_SEQ_LSB = 0;

endpackage

// File: rtl/fifo.sv
// Synchronous single-clock FIFO with valid/ready on both sides; DEPTH must be a power of two.
module fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign in_rdy   = (count != (AW+1)'(DEPTH));
  assign out_val  = (count != '0);
  assign out_data = mem[rd_ptr];
  assign push     = in_val & in_rdy;
  assign pop      = out_val & out_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the last granted index + 1; grant is combinational.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic          gnt_val,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] last_q;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_val = 1'b0;
    gnt_idx = last_q;
    cand    = last_q;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last_q) + k) % N);
      if (!gnt_val && req[cand]) begin
        gnt_val = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IW'(N - 1);
    end else if (advance && gnt_val) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/chnl_tx_mux.sv
// Merges N_SRC buffered producer streams onto one Riffa CHNL TX channel.
// Each transfer is a header beat (source id, length, sequence) followed by the payload.
module chnl_tx_mux
  import chnl_tx_mux_pkg::*;
#(
  parameter int unsigned C_PCI_DATA_WIDTH = 32,
  parameter int unsigned N_SRC            = 2,
  parameter int unsigned CHNL_ALIGN       = 4,
  parameter int unsigned MAX_LENGTH       = 32,
  parameter int unsigned MAX_IDLE_CYCLES  = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_SRC-1:0]                  i_val,
  output logic [N_SRC-1:0]                  i_rdy,
  input  logic [N_SRC*C_PCI_DATA_WIDTH-1:0] i_data,
  output logic                              CHNL_TX_CLK,
  output logic                              CHNL_TX,
  input  logic                              CHNL_TX_ACK,
  output logic                              CHNL_TX_LAST,
  output logic [31:0]                       CHNL_TX_LEN,
  output logic [30:0]                       CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]       CHNL_TX_DATA,
  output logic                              CHNL_TX_DATA_VALID,
  input  logic                              CHNL_TX_DATA_REN
);

  localparam int unsigned W          = C_PCI_DATA_WIDTH;
  localparam int unsigned HW         = W / 32;
  localparam int unsigned ALIGN      = CHNL_ALIGN / HW;
  localparam int unsigned MAXB       = MAX_LENGTH / HW;
  localparam int unsigned IW         = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned LEFT_W     = $clog2(MAXB + 1);
  localparam int unsigned IDLE_W     = (MAX_IDLE_CYCLES > 0) ? $clog2(MAX_IDLE_CYCLES + 1) : 1;
  localparam int unsigned FIFO_DEPTH = 32'd1 << $clog2(2 * MAXB);

  state_t              state_q, state_d;
  logic [IW-1:0]       sel_q;
  logic [LEFT_W-1:0]   len_q;
  logic [LEFT_W-1:0]   left_q;
  logic [SEQ_W-1:0]    seq_lat_q;
  logic [SEQ_W-1:0]    seq_q    [N_SRC];
  logic [31:0]         queued_q [N_SRC];
  logic [IDLE_W-1:0]   idle_q   [N_SRC];

  logic [N_SRC-1:0]    enq;
  logic [N_SRC-1:0]    full_v;
  logic [N_SRC-1:0]    flush_v;
  logic [N_SRC-1:0]    req;
  logic [N_SRC-1:0]    fifo_rd;
  logic [N_SRC-1:0]    f_out_val;
  logic [W-1:0]        f_out_data [N_SRC];
  logic                gnt_val;
  logic [IW-1:0]       gnt_idx;
  logic [31:0]         gnt_q32;
  logic [LEFT_W-1:0]   gnt_len;
  logic                take_grant;
  logic                beat;
  logic                done;
  logic                unused_ack;

  assign unused_ack   = CHNL_TX_ACK;
  assign CHNL_TX_CLK  = clk;
  assign CHNL_TX_LAST = 1'b1;
  assign CHNL_TX_OFF  = '0;
  assign enq          = i_val & i_rdy;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .in_val   (i_val[g]),
      .in_rdy   (i_rdy[g]),
      .in_data  (i_data[g*W +: W]),
      .out_val  (f_out_val[g]),
      .out_rdy  (fifo_rd[g]),
      .out_data (f_out_data[g])
    );
  end

  // Eligibility uses only committed (enqueued, not yet granted) counts.
  always_comb begin
    full_v  = '0;
    flush_v = '0;
    req     = '0;
    for (int s = 0; s < N_SRC; s++) begin
      full_v[s]  = (queued_q[s] >= MAXB);
      flush_v[s] = (MAX_IDLE_CYCLES != 0) && (32'(idle_q[s]) >= MAX_IDLE_CYCLES) &&
                   (queued_q[s] >= ALIGN);
      req[s]     = (state_q == S_IDLE) && (full_v[s] || flush_v[s]);
    end
  end

  rr_arbiter #(
    .N  (N_SRC),
    .IW (IW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (take_grant),
    .gnt_val (gnt_val),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    gnt_q32 = queued_q[gnt_idx];
    if (full_v[gnt_idx]) gnt_len = LEFT_W'(MAXB);
    else                 gnt_len = LEFT_W'(gnt_q32 - (gnt_q32 % ALIGN));
  end

  assign CHNL_TX_LEN = take_grant ? 32'((32'(gnt_len) + 32'd1) * HW)
                                  : 32'((32'(len_q) + 32'd1) * HW);

  // Next-state and channel outputs.
  always_comb begin
    state_d            = state_q;
    CHNL_TX            = 1'b0;
    CHNL_TX_DATA_VALID = 1'b0;
    CHNL_TX_DATA       = '0;
    fifo_rd            = '0;
    take_grant         = 1'b0;
    beat               = 1'b0;
    done               = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_val) begin
          take_grant = 1'b1;
          CHNL_TX    = 1'b1;
          state_d    = S_HEADER;
        end
      end
      S_HEADER: begin
        CHNL_TX            = 1'b1;
        CHNL_TX_DATA_VALID = 1'b1;
        CHNL_TX_DATA[HDR_SEL_LSB +: HDR_SEL_W] = HDR_SEL_W'(sel_q);
        CHNL_TX_DATA[HDR_LEN_LSB +: HDR_LEN_W] = HDR_LEN_W'(32'(len_q) * HW);
        CHNL_TX_DATA[HDR_SEQ_LSB +: SEQ_W]     = seq_lat_q;
        if (CHNL_TX_DATA_REN) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        CHNL_TX            = 1'b1;
        CHNL_TX_DATA_VALID = f_out_val[sel_q];
        CHNL_TX_DATA       = f_out_data[sel_q];
        fifo_rd[sel_q]     = CHNL_TX_DATA_REN;
        if (CHNL_TX_DATA_REN && f_out_val[sel_q]) begin
          beat = 1'b1;
          if (left_q == LEFT_W'(1)) begin
            CHNL_TX = 1'b0;
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      len_q     <= '0;
      left_q    <= '0;
      seq_lat_q <= '0;
      for (int s = 0; s < N_SRC; s++) begin
        seq_q[s]    <= '0;
        queued_q[s] <= '0;
        idle_q[s]   <= '0;
      end
    end else begin
      state_q <= state_d;
      if (take_grant) begin
        sel_q     <= gnt_idx;
        len_q     <= gnt_len;
        seq_lat_q <= seq_q[gnt_idx];
      end
      if (state_q == S_HEADER && CHNL_TX_DATA_REN) left_q <= len_q;
      else if (beat)                               left_q <= left_q - LEFT_W'(1);
      if (done) seq_q[sel_q] <= seq_q[sel_q] + SEQ_W'(1);
      for (int s = 0; s < N_SRC; s++) begin
        queued_q[s] <= queued_q[s] + 32'(enq[s]) -
                       ((take_grant && gnt_idx == IW'(s)) ? 32'(gnt_len) : 32'd0);
        if (enq[s])
          idle_q[s] <= '0;
        else if (!i_val[s] && 32'(idle_q[s]) < MAX_IDLE_CYCLES)
          idle_q[s] <= idle_q[s] + IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_chnl_tx_mux.sv
// Directed self-checking bench for chnl_tx_mux (N_SRC=2, W=32), plus a
// second instance with the idle timeout disabled.
module tb_chnl_tx_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  i_val, i_rdy;
  logic [63:0] i_data;
  logic        tx_clk, tx, last, dv, ren;
  logic [31:0] len, data;
  logic [30:0] off;
  logic [1:0]  z_val, z_rdy;
  logic [63:0] z_data;
  logic        z_tx_clk, z_tx, z_last, z_dv, z_ren;
  logic [31:0] z_len, z_data_o;
  logic [30:0] z_off;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cap_len;
  logic [31:0] cap_hdr;
  logic [31:0] cap_pay [64];
  int          cap_n;
  bit          cap_ok;
  logic        cap_last_tx;

  always #5 clk = ~clk;

  chnl_tx_mux #(
    .C_PCI_DATA_WIDTH (32), .N_SRC (2), .CHNL_ALIGN (4), .MAX_LENGTH (32), .MAX_IDLE_CYCLES (128)
  ) dut (
    .clk (clk), .rst (rst), .i_val (i_val), .i_rdy (i_rdy), .i_data (i_data),
    .CHNL_TX_CLK (tx_clk), .CHNL_TX (tx), .CHNL_TX_ACK (1'b0), .CHNL_TX_LAST (last),
    .CHNL_TX_LEN (len), .CHNL_TX_OFF (off), .CHNL_TX_DATA (data),
    .CHNL_TX_DATA_VALID (dv), .CHNL_TX_DATA_REN (ren)
  );

  chnl_tx_mux #(
    .C_PCI_DATA_WIDTH (32), .N_SRC (2), .CHNL_ALIGN (4), .MAX_LENGTH (32), .MAX_IDLE_CYCLES (0)
  ) dut_z (
    .clk (clk), .rst (rst), .i_val (z_val), .i_rdy (z_rdy), .i_data (z_data),
    .CHNL_TX_CLK (z_tx_clk), .CHNL_TX (z_tx), .CHNL_TX_ACK (1'b0), .CHNL_TX_LAST (z_last),
    .CHNL_TX_LEN (z_len), .CHNL_TX_OFF (z_off), .CHNL_TX_DATA (z_data_o),
    .CHNL_TX_DATA_VALID (z_dv), .CHNL_TX_DATA_REN (z_ren)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; i_val = '0; i_data = '0; z_val = '0; z_data = '0; ren = 1'b1; z_ren = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push(input int s, input int n, input logic [31:0] base);
    bit ok;
    int guard;
    for (int i = 0; i < n; i++) begin
      i_val[s] = 1'b1;
      i_data[s*32 +: 32] = base + 32'(i);
      guard = 0;
      do begin
        ok = i_rdy[s];
        @(posedge clk); #1;
        guard++;
      end while (!ok && guard < 1000);
    end
    i_val[s] = 1'b0;
  endtask

  task automatic push_both(input int n, input logic [31:0] b0, input logic [31:0] b1);
    for (int i = 0; i < n; i++) begin
      i_val = 2'b11;
      i_data = {b1 + 32'(i), b0 + 32'(i)};
      @(posedge clk); #1;
    end
    i_val = 2'b00;
  endtask

  // Capture one transfer (request, header, payload); no checking here.
  task automatic recv(input int max_wait, input bit toggle);
    int  cyc;
    bit  got_hdr;
    bit  ph;
    cap_ok = 1'b0; cap_n = 0; got_hdr = 1'b0; ph = 1'b0; cyc = 0;
    cap_last_tx = 1'bx; cap_hdr = 'x; cap_len = 'x;
    while (tx !== 1'b1 && cyc < max_wait) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (tx !== 1'b1) return;
    cap_len = len;
    if (cap_len == 0 || cap_len > 64) return;
    while (cyc < max_wait) begin
      @(posedge clk); #1;
      ren = toggle ? ph : 1'b1;
      ph = ~ph;
      #1;
      cyc++;
      if (dv === 1'b1 && ren) begin
        if (!got_hdr) begin
          cap_hdr = data;
          got_hdr = 1'b1;
        end else begin
          cap_pay[cap_n] = data;
          cap_n++;
          if (cap_n == int'(cap_len) - 1) begin
            cap_last_tx = tx;
            cap_ok = 1'b1;
            return;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (tx !== 1'b0)    begin n_err++; $display("FAIL reset_tx: got %b want 0", tx); end
    n_cmp++; if (dv !== 1'b0)    begin n_err++; $display("FAIL reset_valid: got %b want 0", dv); end
    n_cmp++; if (i_rdy !== 2'b11) begin n_err++; $display("FAIL reset_rdy: got %b want 11", i_rdy); end
    n_cmp++; if (last !== 1'b1)  begin n_err++; $display("FAIL reset_last: got %b want 1", last); end
    n_cmp++; if (off !== 31'd0)  begin n_err++; $display("FAIL reset_off: got %h want 0", off); end
  endtask

  task automatic test_single();
    do_reset();
    push(0, 32, 32'h1000);
    recv(100, 1'b0);
    n_cmp++; if (cap_ok !== 1'b1) begin n_err++; $display("FAIL single_done: got %b want 1", cap_ok); end
    n_cmp++; if (cap_len !== 32'd33) begin n_err++; $display("FAIL single_len: got %0d want 33", cap_len); end
    n_cmp++; if (cap_hdr !== 32'h00002000) begin n_err++; $display("FAIL single_hdr: got %h want 00002000", cap_hdr); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap_pay[i] !== 32'h1000 + 32'(i)) begin
        n_err++; $display("FAIL single_pay[%0d]: got %h want %h", i, cap_pay[i], 32'h1000 + 32'(i));
      end
    end
    n_cmp++; if (cap_last_tx !== 1'b0) begin n_err++; $display("FAIL single_last_tx: got %b want 0", cap_last_tx); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want_hdr [4];
    logic [31:0] want_base [4];
    want_hdr  = '{32'h00002000, 32'h01002000, 32'h00002001, 32'h01002001};
    want_base = '{32'hA00, 32'hB00, 32'hC00, 32'hD00};
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_both(32, want_base[2*r], want_base[2*r+1]);
      for (int t = 0; t < 2; t++) begin
        recv(200, 1'b0);
        n_cmp++; if (cap_len !== 32'd33) begin n_err++; $display("FAIL b2b_len[%0d]: got %0d want 33", 2*r+t, cap_len); end
        n_cmp++;
        if (cap_hdr !== want_hdr[2*r+t]) begin
          n_err++; $display("FAIL b2b_hdr[%0d]: got %h want %h", 2*r+t, cap_hdr, want_hdr[2*r+t]);
        end
        n_cmp++;
        if (cap_pay[0] !== want_base[2*r+t] || cap_pay[31] !== want_base[2*r+t] + 32'd31) begin
          n_err++; $display("FAIL b2b_pay[%0d]: got %h..%h want %h..%h", 2*r+t, cap_pay[0], cap_pay[31],
                            want_base[2*r+t], want_base[2*r+t] + 32'd31);
        end
      end
    end
  endtask

  task automatic test_flush();
    int busy;
    do_reset();
    push(1, 6, 32'h2000);
    recv(400, 1'b0);
    n_cmp++; if (cap_len !== 32'd5) begin n_err++; $display("FAIL flush_len: got %0d want 5", cap_len); end
    n_cmp++; if (cap_hdr !== 32'h01000400) begin n_err++; $display("FAIL flush_hdr: got %h want 01000400", cap_hdr); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_pay[i] !== 32'h2000 + 32'(i)) begin
        n_err++; $display("FAIL flush_pay[%0d]: got %h want %h", i, cap_pay[i], 32'h2000 + 32'(i));
      end
    end
    busy = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (tx === 1'b1) busy++;
    end
    n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL flush_residue_held: got %0d busy cycles want 0", busy); end
    push(1, 2, 32'h2006);
    recv(400, 1'b0);
    n_cmp++; if (cap_len !== 32'd5) begin n_err++; $display("FAIL flush2_len: got %0d want 5", cap_len); end
    n_cmp++; if (cap_hdr !== 32'h01000401) begin n_err++; $display("FAIL flush2_hdr: got %h want 01000401", cap_hdr); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (cap_pay[i] !== 32'h2004 + 32'(i)) begin
        n_err++; $display("FAIL flush2_pay[%0d]: got %h want %h", i, cap_pay[i], 32'h2004 + 32'(i));
      end
    end
  endtask

  task automatic test_no_flush();
    int busy, z_busy;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      i_val[0] = 1'b1; i_data[31:0] = 32'h3300 + 32'(i);
      z_val[0] = 1'b1; z_data[31:0] = 32'h3300 + 32'(i);
      @(posedge clk); #1;
    end
    i_val = '0; z_val = '0;
    busy = 0; z_busy = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (tx === 1'b1) busy++;
      if (z_tx === 1'b1 || z_dv === 1'b1) z_busy++;
    end
    n_cmp++; if (z_busy !== 0) begin n_err++; $display("FAIL noflush_disabled: got %0d busy cycles want 0", z_busy); end
    n_cmp++; if (busy !== 0) begin n_err++; $display("FAIL noflush_below_align: got %0d busy cycles want 0", busy); end
    n_cmp++; if (z_rdy !== 2'b11) begin n_err++; $display("FAIL noflush_rdy: got %b want 11", z_rdy); end
  endtask

  task automatic test_ren_toggle();
    do_reset();
    push(0, 32, 32'h3000);
    fork
      recv(300, 1'b1);
      push(0, 32, 32'h4000);
    join
    n_cmp++; if (cap_ok !== 1'b1) begin n_err++; $display("FAIL toggle_done: got %b want 1", cap_ok); end
    n_cmp++; if (cap_hdr !== 32'h00002000) begin n_err++; $display("FAIL toggle_hdr: got %h want 00002000", cap_hdr); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap_pay[i] !== 32'h3000 + 32'(i)) begin
        n_err++; $display("FAIL toggle_pay[%0d]: got %h want %h", i, cap_pay[i], 32'h3000 + 32'(i));
      end
    end
    recv(200, 1'b0);
    n_cmp++; if (cap_len !== 32'd33) begin n_err++; $display("FAIL toggle2_len: got %0d want 33", cap_len); end
    n_cmp++; if (cap_hdr !== 32'h00002001) begin n_err++; $display("FAIL toggle2_hdr: got %h want 00002001", cap_hdr); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (cap_pay[i] !== 32'h4000 + 32'(i)) begin
        n_err++; $display("FAIL toggle2_pay[%0d]: got %h want %h", i, cap_pay[i], 32'h4000 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(0, 32, 32'h5000);
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (tx !== 1'b1 || dv !== 1'b1) begin n_err++; $display("FAIL mid_busy: got tx=%b dv=%b want 1 1", tx, dv); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL mid_tx: got %b want 0", tx); end
    n_cmp++; if (dv !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", dv); end
    n_cmp++; if (i_rdy !== 2'b11) begin n_err++; $display("FAIL mid_rdy: got %b want 11", i_rdy); end
    push(0, 32, 32'h6000);
    recv(100, 1'b0);
    n_cmp++; if (cap_hdr !== 32'h00002000) begin n_err++; $display("FAIL mid_hdr: got %h want 00002000", cap_hdr); end
    n_cmp++; if (cap_pay[0] !== 32'h6000) begin n_err++; $display("FAIL mid_pay0: got %h want 6000", cap_pay[0]); end
    n_cmp++; if (cap_pay[31] !== 32'h601F) begin n_err++; $display("FAIL mid_pay31: got %h want 601f", cap_pay[31]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_no_flush();
    test_ren_toggle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
